// File: rtl/cl2_pl_exu_wbu.sv
// CL2 execute write-back unit: merges ALU results and in-order LSU load responses onto the
// single regfile write port, and tracks outstanding load destinations for hazard checks.
module cl2_pl_exu_wbu #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RF_AW    = 5,
  parameter int unsigned RF_NUM   = 32,
  parameter int unsigned LD_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             alu_wb_valid_i,
  input  logic [RF_AW-1:0] alu_wb_idx_i,
  input  logic [XLEN-1:0]  alu_wb_dat_i,
  input  logic             ld_issue_valid_i,
  input  logic [RF_AW-1:0] ld_issue_idx_i,
  output logic             ld_issue_ready_o,
  input  logic             ld_rsp_valid_i,
  input  logic [XLEN-1:0]  ld_rsp_dat_i,
  output logic             ld_rsp_ready_o,
  input  logic [RF_AW-1:0] rs1_idx_i,
  input  logic [RF_AW-1:0] rs2_idx_i,
  output logic             rs1_busy_o,
  output logic             rs2_busy_o,
  output logic             wd_wen_o,
  output logic [RF_AW-1:0] wd_idx_o,
  output logic [XLEN-1:0]  wd_dat_o
);

  localparam int unsigned PtrW = $clog2(LD_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [RF_NUM-1:0] busy_q, busy_d;
  logic [RF_AW-1:0]  fifo_q [LD_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              wd_wen_q, wd_wen_d;
  logic              wd_ld_q, wd_ld_d;
  logic [RF_AW-1:0]  wd_idx_q, wd_idx_d;
  logic [XLEN-1:0]   wd_dat_q, wd_dat_d;

  logic             issue_fire, rsp_fire;
  logic [RF_AW-1:0] head_idx;

  assign head_idx         = fifo_q[rd_ptr_q];
  assign ld_issue_ready_o = (cnt_q != CntW'(LD_DEPTH)) && !busy_q[ld_issue_idx_i];
  // ALU results have no back-pressure, so a load response yields to them.
  assign ld_rsp_ready_o   = (cnt_q != '0) && !alu_wb_valid_i;
  assign issue_fire       = ld_issue_valid_i && ld_issue_ready_o;
  assign rsp_fire         = ld_rsp_valid_i && ld_rsp_ready_o;

  assign rs1_busy_o = busy_q[rs1_idx_i];
  assign rs2_busy_o = busy_q[rs2_idx_i];
  assign wd_wen_o   = wd_wen_q;
  assign wd_idx_o   = wd_idx_q;
  assign wd_dat_o   = wd_dat_q;

  always_comb begin
    busy_d = busy_q;
    // Clear on the edge where the regfile captures the load data; a same-edge set wins.
    if (wd_wen_q && wd_ld_q) begin
      busy_d[wd_idx_q] = 1'b0;
    end
    if (issue_fire && (ld_issue_idx_i != '0)) begin
      busy_d[ld_issue_idx_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({issue_fire, rsp_fire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    wd_wen_d = 1'b0;
    wd_ld_d  = 1'b0;
    wd_idx_d = wd_idx_q;
    wd_dat_d = wd_dat_q;
    if (alu_wb_valid_i) begin
      wd_wen_d = (alu_wb_idx_i != '0);
      wd_idx_d = alu_wb_idx_i;
      wd_dat_d = alu_wb_dat_i;
    end else if (rsp_fire) begin
      // x0 destinations still pop the FIFO but never write.
      wd_wen_d = (head_idx != '0);
      wd_ld_d  = 1'b1;
      wd_idx_d = head_idx;
      wd_dat_d = ld_rsp_dat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      wd_wen_q <= 1'b0;
      wd_ld_q  <= 1'b0;
      wd_idx_q <= '0;
      wd_dat_q <= '0;
      for (int i = 0; i < int'(LD_DEPTH); i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      wd_wen_q <= wd_wen_d;
      wd_ld_q  <= wd_ld_d;
      wd_idx_q <= wd_idx_d;
      wd_dat_q <= wd_dat_d;
      if (issue_fire) begin
        fifo_q[wr_ptr_q] <= ld_issue_idx_i;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (rsp_fire) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cl2_pl_exu_wbu.sv
// Bench for cl2_pl_exu_wbu: directed vector table, mid-operation reset, then random traffic
// checked against a queue-based model of outstanding loads.
module tb_cl2_pl_exu_wbu;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned RF_AW    = 5;
  localparam int unsigned LD_DEPTH = 4;

  logic             clk_i = 1'b0;
  logic             rst_n_i;
  logic             alu_wb_valid_i;
  logic [RF_AW-1:0] alu_wb_idx_i;
  logic [XLEN-1:0]  alu_wb_dat_i;
  logic             ld_issue_valid_i;
  logic [RF_AW-1:0] ld_issue_idx_i;
  logic             ld_issue_ready_o;
  logic             ld_rsp_valid_i;
  logic [XLEN-1:0]  ld_rsp_dat_i;
  logic             ld_rsp_ready_o;
  logic [RF_AW-1:0] rs1_idx_i, rs2_idx_i;
  logic             rs1_busy_o, rs2_busy_o;
  logic             wd_wen_o;
  logic [RF_AW-1:0] wd_idx_o;
  logic [XLEN-1:0]  wd_dat_o;

  cl2_pl_exu_wbu #(
    .XLEN    (XLEN),
    .RF_AW   (RF_AW),
    .RF_NUM  (32),
    .LD_DEPTH(LD_DEPTH)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .alu_wb_valid_i  (alu_wb_valid_i),
    .alu_wb_idx_i    (alu_wb_idx_i),
    .alu_wb_dat_i    (alu_wb_dat_i),
    .ld_issue_valid_i(ld_issue_valid_i),
    .ld_issue_idx_i  (ld_issue_idx_i),
    .ld_issue_ready_o(ld_issue_ready_o),
    .ld_rsp_valid_i  (ld_rsp_valid_i),
    .ld_rsp_dat_i    (ld_rsp_dat_i),
    .ld_rsp_ready_o  (ld_rsp_ready_o),
    .rs1_idx_i       (rs1_idx_i),
    .rs2_idx_i       (rs2_idx_i),
    .rs1_busy_o      (rs1_busy_o),
    .rs2_busy_o      (rs2_busy_o),
    .wd_wen_o        (wd_wen_o),
    .wd_idx_o        (wd_idx_o),
    .wd_dat_o        (wd_dat_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit               av;
    logic [RF_AW-1:0] ai;
    logic [XLEN-1:0]  ad;
    bit               iv;
    logic [RF_AW-1:0] ii;
    bit               rv;
    logic [XLEN-1:0]  rd;
    logic [RF_AW-1:0] q1, q2;
    bit               e_ir, e_rr, e_b1, e_b2, e_wen;
    logic [RF_AW-1:0] e_wi;
    logic [XLEN-1:0]  e_wd;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: loads issued but not yet returned, plus the register whose load data
  // is on the write port this cycle (still busy until the end of that cycle).
  int pend[$];
  int wb_reg = 0;

  function automatic bit m_busy(input int r);
    if (r == 0) return 1'b0;
    if (r == wb_reg) return 1'b1;
    foreach (pend[k]) if (pend[k] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void add(input int av, input int ai, input int ad, input int iv,
                              input int ii, input int rv, input int rd, input int q1,
                              input int q2, input int e_ir, input int e_rr, input int e_b1,
                              input int e_b2, input int e_wen, input int e_wi, input int e_wd);
    vec_t v;
    v.av = av[0];   v.ai = RF_AW'(ai); v.ad = XLEN'(ad);
    v.iv = iv[0];   v.ii = RF_AW'(ii); v.rv = rv[0];       v.rd = XLEN'(rd);
    v.q1 = RF_AW'(q1); v.q2 = RF_AW'(q2);
    v.e_ir = e_ir[0]; v.e_rr = e_rr[0]; v.e_b1 = e_b1[0]; v.e_b2 = e_b2[0];
    v.e_wen = e_wen[0]; v.e_wi = RF_AW'(e_wi); v.e_wd = XLEN'(e_wd);
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic drive_idle();
    alu_wb_valid_i = 1'b0; alu_wb_idx_i = '0; alu_wb_dat_i = '0;
    ld_issue_valid_i = 1'b0; ld_issue_idx_i = '0;
    ld_rsp_valid_i = 1'b0; ld_rsp_dat_i = '0;
    rs1_idx_i = '0; rs2_idx_i = '0;
  endtask

  // One cycle: drive, check combinational outputs, clock, check the registered write.
  task automatic apply(input vec_t v);
    alu_wb_valid_i   = v.av; alu_wb_idx_i   = v.ai; alu_wb_dat_i = v.ad;
    ld_issue_valid_i = v.iv; ld_issue_idx_i = v.ii;
    ld_rsp_valid_i   = v.rv; ld_rsp_dat_i   = v.rd;
    rs1_idx_i        = v.q1; rs2_idx_i      = v.q2;
    #1;
    n_vec++;
    chk("ld_issue_ready", 32'(ld_issue_ready_o), 32'(v.e_ir));
    chk("ld_rsp_ready", 32'(ld_rsp_ready_o), 32'(v.e_rr));
    chk("rs1_busy", 32'(rs1_busy_o), 32'(v.e_b1));
    chk("rs2_busy", 32'(rs2_busy_o), 32'(v.e_b2));
    @(posedge clk_i);
    #1;
    chk("wd_wen", 32'(wd_wen_o), 32'(v.e_wen));
    if (v.e_wen) begin
      chk("wd_idx", 32'(wd_idx_o), 32'(v.e_wi));
      chk("wd_dat", wd_dat_o, v.e_wd);
    end
  endtask

  // Upstream must never send an ALU write to a register with a pending load.
  always @(negedge clk_i) begin
    if (rst_n_i && alu_wb_valid_i && (rs1_idx_i == alu_wb_idx_i)) begin
      assert (!rs1_busy_o)
      else begin
        n_err++;
        $error("FAIL alu_write_to_busy: x%0d busy=%0b, required 0", alu_wb_idx_i, rs1_busy_o);
      end
    end
  end

  initial begin
    vec_t v;
    int   head;
    int   new_wb;

    drive_idle();
    rst_n_i = 1'b0;
    #23;
    n_vec++;
    chk("rst_wd_wen", 32'(wd_wen_o), 32'd0);
    chk("rst_wd_idx", 32'(wd_idx_o), 32'd0);
    chk("rst_wd_dat", wd_dat_o, 32'd0);
    chk("rst_issue_ready", 32'(ld_issue_ready_o), 32'd1);
    chk("rst_rsp_ready", 32'(ld_rsp_ready_o), 32'd0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    //   av ai ad           iv ii rv rd       q1 q2 ir rr b1 b2 wen wi wd
    add(1, 5, 'hDEADBEEF, 0, 0, 0, 0,       0, 0, 1, 0, 0, 0, 1, 5, 'hDEADBEEF);
    add(1, 0, 'h1234,     0, 0, 0, 0,       0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,          1, 7, 0, 0,       7, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,          0, 0, 0, 0,       7, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0,          0, 0, 1, 'h1234,  7, 0, 1, 1, 1, 0, 1, 7, 'h1234);
    add(0, 0, 0,          0, 0, 0, 0,       7, 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0,          0, 0, 0, 0,       7, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,          1, 1, 0, 0,       1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,          1, 2, 0, 0,       1, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0,          1, 3, 0, 0,       2, 3, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0,          1, 4, 0, 0,       3, 4, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0,          1, 5, 0, 0,       4, 5, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0,          1, 5, 1, 'hA,     1, 0, 0, 1, 1, 0, 1, 1, 'hA);
    add(0, 0, 0,          1, 5, 1, 'hB,     1, 0, 1, 1, 1, 0, 1, 2, 'hB);
    add(0, 0, 0,          0, 0, 1, 'hC,     1, 2, 1, 1, 0, 1, 1, 3, 'hC);
    add(0, 0, 0,          0, 0, 1, 'hD,     2, 5, 1, 1, 0, 1, 1, 4, 'hD);
    add(1, 9, 'h99,       0, 0, 1, 'h55,    5, 0, 1, 0, 1, 0, 1, 9, 'h99);
    add(0, 0, 0,          0, 0, 1, 'h55,    9, 0, 1, 1, 0, 0, 1, 5, 'h55);
    add(0, 0, 0,          0, 0, 0, 0,       5, 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0,          0, 0, 0, 0,       5, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,          1, 3, 0, 0,       0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,          1, 3, 0, 0,       3, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0,          1, 3, 1, 'h33,    3, 0, 0, 1, 1, 0, 1, 3, 'h33);
    add(0, 0, 0,          1, 3, 0, 0,       3, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0,          1, 3, 0, 0,       3, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,          0, 0, 0, 0,       3, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0,          1, 0, 1, 'h77,    3, 0, 1, 1, 1, 0, 1, 3, 'h77);
    add(0, 0, 0,          0, 0, 1, 'h88,    3, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0,          0, 0, 1, 'hEE,    3, 0, 1, 0, 0, 0, 0, 0, 0);
    // Two loads outstanding and an ALU beat on the port, then reset mid-cycle.
    add(0, 0, 0,          1, 10, 0, 0,      0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0,          1, 11, 0, 0,      10, 0, 1, 1, 1, 0, 0, 0, 0);
    add(1, 12, 'hC0FFEE,  0, 0, 0, 0,       10, 11, 1, 0, 1, 1, 1, 12, 'hC0FFEE);

    foreach (tbl[i]) apply(tbl[i]);

    drive_idle();
    rs1_idx_i = 5'd10; rs2_idx_i = 5'd11; ld_rsp_valid_i = 1'b1;
    #2;
    rst_n_i = 1'b0;
    #1;
    n_vec++;
    chk("midrst_wd_wen", 32'(wd_wen_o), 32'd0);
    chk("midrst_rsp_ready", 32'(ld_rsp_ready_o), 32'd0);
    chk("midrst_rs1_busy", 32'(rs1_busy_o), 32'd0);
    chk("midrst_rs2_busy", 32'(rs2_busy_o), 32'd0);
    chk("midrst_issue_ready", 32'(ld_issue_ready_o), 32'd1);
    drive_idle();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    for (int n = 0; n < 600; n++) begin
      v.iv = 1'($urandom_range(0, 1));
      v.ii = RF_AW'($urandom_range(0, 7));
      v.rv = ($urandom_range(0, 2) != 0);
      v.rd = $urandom;
      v.ai = RF_AW'($urandom_range(0, 7));
      v.ad = $urandom;
      v.av = ($urandom_range(0, 3) == 0) && !m_busy(int'(v.ai));
      v.q1 = RF_AW'($urandom_range(0, 7));
      v.q2 = RF_AW'($urandom_range(0, 7));

      v.e_ir = (pend.size() != LD_DEPTH) && !m_busy(int'(v.ii));
      v.e_rr = (pend.size() != 0) && !v.av;
      v.e_b1 = m_busy(int'(v.q1));
      v.e_b2 = m_busy(int'(v.q2));
      v.e_wen = 1'b0; v.e_wi = '0; v.e_wd = '0;
      new_wb = 0;
      if (v.av) begin
        v.e_wen = (v.ai != '0); v.e_wi = v.ai; v.e_wd = v.ad;
      end else if (v.rv && v.e_rr) begin
        head = pend.pop_front();
        v.e_wen = (head != 0); v.e_wi = RF_AW'(head); v.e_wd = v.rd;
        new_wb = head;
      end
      if (v.iv && v.e_ir) pend.push_back(int'(v.ii));
      wb_reg = new_wb;
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
